// File: rtl/rs_multi_cdb_pkg.sv
// Shared widths, default sizes and opcode class encodings for the ALU
// reservation station and its age-select helper.
package rs_multi_cdb_pkg;

  localparam int RS_SIZE_DEF = 8;
  localparam int ROB_W_DEF   = 4;
  localparam int NUM_CDB_DEF = 2;
  localparam int XLEN        = 32;

  typedef logic [2:0] funct3_t;
  typedef logic [6:0] opclass_t;

  localparam opclass_t OPC_OP     = 7'b0110011;
  localparam opclass_t OPC_OP_IMM = 7'b0010011;
  localparam opclass_t OPC_LUI    = 7'b0110111;
  localparam opclass_t OPC_AUIPC  = 7'b0010111;
  localparam opclass_t OPC_BRANCH = 7'b1100011;
  localparam opclass_t OPC_JAL    = 7'b1101111;
  localparam opclass_t OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/rs_multi_cdb_age_select.sv
// Age matrix plus oldest-ready picker; older[i][j]=1 means entry i was
// allocated before entry j. Usable by any station with an N-entry pool.
module rs_age_select
  import rs_multi_cdb_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             alloc,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic [N-1:0]     busy,
  input  logic [N-1:0]     ready,
  output logic             sel_valid,
  output logic [N-1:0]     sel_onehot,
  output logic [IDX_W-1:0] sel_idx
);

  logic [N-1:0] older [N];
  logic [N-1:0] blocked;

  // Row of the new entry cleared, its column copied from the current busy set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) older[i] <= '0;
    end else if (en) begin
      if (clear) begin
        for (int i = 0; i < N; i++) older[i] <= '0;
      end else if (alloc) begin
        for (int i = 0; i < N; i++) begin
          older[alloc_idx][i] <= 1'b0;
          older[i][alloc_idx] <= busy[i];
        end
      end
    end
  end

  always_comb begin
    blocked    = '0;
    sel_onehot = '0;
    sel_idx    = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
      sel_onehot[i] = ready[i] & ~blocked[i];
    end
    for (int i = 0; i < N; i++) begin
      if (sel_onehot[i]) sel_idx = IDX_W'(i);
    end
    sel_valid = |sel_onehot;
  end

endmodule

// File: rtl/rs_multi_cdb.sv
// ALU reservation station: multi-CDB operand wakeup, issue bypass,
// oldest-first select into a registered valid/ready output stage.
module rs_multi_cdb
  import rs_multi_cdb_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int ROB_W   = ROB_W_DEF,
  parameter int NUM_CDB = NUM_CDB_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      rob_clear,
  input  logic                      issue_valid,
  input  logic [2:0]                issue_op,
  input  logic [6:0]                issue_type,
  input  logic                      issue_op_other,
  input  logic [31:0]               issue_v1,
  input  logic [31:0]               issue_v2,
  input  logic                      issue_dep1,
  input  logic                      issue_dep2,
  input  logic [ROB_W-1:0]          issue_tag1,
  input  logic [ROB_W-1:0]          issue_tag2,
  input  logic [ROB_W-1:0]          issue_rob_id,
  output logic                      rs_full,
  output logic [$clog2(RS_SIZE):0]  rs_count,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]  cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]     cdb_value,
  input  logic                      alu_ready,
  output logic                      alu_valid,
  output logic [2:0]                alu_op,
  output logic [6:0]                alu_type,
  output logic                      alu_op_other,
  output logic [31:0]               alu_v1,
  output logic [31:0]               alu_v2,
  output logic [ROB_W-1:0]          alu_rob_id
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RS_SIZE);

  logic [RS_SIZE-1:0] busy, dep1, dep2, oth, ready;
  logic [ROB_W-1:0]   tag1 [RS_SIZE];
  logic [ROB_W-1:0]   tag2 [RS_SIZE];
  logic [ROB_W-1:0]   rob  [RS_SIZE];
  logic [31:0]        val1 [RS_SIZE];
  logic [31:0]        val2 [RS_SIZE];
  funct3_t            op   [RS_SIZE];
  opclass_t           typ  [RS_SIZE];

  logic [NUM_CDB-1:0][RS_SIZE-1:0] hit1, hit2;
  logic [NUM_CDB-1:0] byp_hit1, byp_hit2;
  logic [RS_SIZE-1:0] wake1, wake2;
  logic [31:0]        wval1 [RS_SIZE];
  logic [31:0]        wval2 [RS_SIZE];
  logic               byp1, byp2;
  logic [31:0]        bval1, bval2;

  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic [RS_SIZE-1:0] sel_onehot;
  logic               sel_valid, alloc, load;

  // Only busy entries still waiting on an operand may capture a broadcast
  for (genvar c = 0; c < NUM_CDB; c++) begin : g_cdb
    assign byp_hit1[c] = cdb_valid[c] && (cdb_rob_id[c*ROB_W +: ROB_W] == issue_tag1);
    assign byp_hit2[c] = cdb_valid[c] && (cdb_rob_id[c*ROB_W +: ROB_W] == issue_tag2);
    for (genvar i = 0; i < RS_SIZE; i++) begin : g_ent
      assign hit1[c][i] = cdb_valid[c] && busy[i] && dep1[i] &&
                          (tag1[i] == cdb_rob_id[c*ROB_W +: ROB_W]);
      assign hit2[c][i] = cdb_valid[c] && busy[i] && dep2[i] &&
                          (tag2[i] == cdb_rob_id[c*ROB_W +: ROB_W]);
    end
  end

  always_comb begin
    byp1  = 1'b0;
    byp2  = 1'b0;
    bval1 = '0;
    bval2 = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      wake1[i] = 1'b0;
      wake2[i] = 1'b0;
      wval1[i] = '0;
      wval2[i] = '0;
    end
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (byp_hit1[c]) begin byp1 = 1'b1; bval1 = cdb_value[c*32 +: 32]; end
      if (byp_hit2[c]) begin byp2 = 1'b1; bval2 = cdb_value[c*32 +: 32]; end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (hit1[c][i]) begin wake1[i] = 1'b1; wval1[i] = cdb_value[c*32 +: 32]; end
        if (hit2[c][i]) begin wake2[i] = 1'b1; wval2[i] = cdb_value[c*32 +: 32]; end
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  assign rs_full = (rs_count == FULL_CNT);
  assign alloc   = issue_valid && !rs_full;
  assign ready   = busy & ~dep1 & ~dep2;
  assign load    = (!alu_valid || alu_ready) && sel_valid;

  rs_age_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_age (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (rdy),
    .clear      (rob_clear),
    .alloc      (alloc),
    .alloc_idx  (free_idx),
    .busy       (busy),
    .ready      (ready),
    .sel_valid  (sel_valid),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || (rdy && rob_clear)) begin
      busy         <= '0;
      dep1         <= '0;
      dep2         <= '0;
      rs_count     <= '0;
      alu_valid    <= 1'b0;
      alu_op       <= '0;
      alu_type     <= '0;
      alu_op_other <= 1'b0;
      alu_v1       <= '0;
      alu_v2       <= '0;
      alu_rob_id   <= '0;
    end else if (rdy) begin
      dep1 <= dep1 & ~wake1;
      dep2 <= dep2 & ~wake2;
      busy <= busy & ~(load ? sel_onehot : '0);
      if (alloc) begin
        busy[free_idx] <= 1'b1;
        dep1[free_idx] <= issue_dep1 && !byp1;
        dep2[free_idx] <= issue_dep2 && !byp2;
      end
      rs_count <= rs_count + CNT_W'(alloc) - CNT_W'(load);
      if (load) begin
        alu_valid    <= 1'b1;
        alu_op       <= op[sel_idx];
        alu_type     <= typ[sel_idx];
        alu_op_other <= oth[sel_idx];
        alu_v1       <= val1[sel_idx];
        alu_v2       <= val2[sel_idx];
        alu_rob_id   <= rob[sel_idx];
      end else if (alu_ready) begin
        alu_valid <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset: busy/dep gate every use of it
  always_ff @(posedge clk) begin
    if (rst_n && rdy && !rob_clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (wake1[i]) val1[i] <= wval1[i];
        if (wake2[i]) val2[i] <= wval2[i];
      end
      if (alloc) begin
        op[free_idx]   <= issue_op;
        typ[free_idx]  <= issue_type;
        oth[free_idx]  <= issue_op_other;
        rob[free_idx]  <= issue_rob_id;
        tag1[free_idx] <= issue_tag1;
        tag2[free_idx] <= issue_tag2;
        val1[free_idx] <= (issue_dep1 && byp1) ? bval1 : issue_v1;
        val2[free_idx] <= (issue_dep2 && byp2) ? bval2 : issue_v2;
      end
    end
  end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: queue-based age-ordered reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_rs_multi_cdb;

  localparam int RS_SIZE = 8;
  localparam int ROB_W   = 4;
  localparam int NUM_CDB = 2;

  logic                     clk = 1'b0;
  logic                     rst_n, rdy, rob_clear, issue_valid;
  logic [2:0]               issue_op;
  logic [6:0]               issue_type;
  logic                     issue_op_other;
  logic [31:0]              issue_v1, issue_v2;
  logic                     issue_dep1, issue_dep2;
  logic [ROB_W-1:0]         issue_tag1, issue_tag2, issue_rob_id;
  logic                     rs_full;
  logic [$clog2(RS_SIZE):0] rs_count;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id;
  logic [NUM_CDB*32-1:0]    cdb_value;
  logic                     alu_ready, alu_valid, alu_op_other;
  logic [2:0]               alu_op;
  logic [6:0]               alu_type;
  logic [31:0]              alu_v1, alu_v2;
  logic [ROB_W-1:0]         alu_rob_id;

  rs_multi_cdb #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rob_clear(rob_clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_type(issue_type),
    .issue_op_other(issue_op_other), .issue_v1(issue_v1), .issue_v2(issue_v2),
    .issue_dep1(issue_dep1), .issue_dep2(issue_dep2), .issue_tag1(issue_tag1),
    .issue_tag2(issue_tag2), .issue_rob_id(issue_rob_id), .rs_full(rs_full),
    .rs_count(rs_count), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_value(cdb_value), .alu_ready(alu_ready), .alu_valid(alu_valid),
    .alu_op(alu_op), .alu_type(alu_type), .alu_op_other(alu_op_other),
    .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_rob_id(alu_rob_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             dep1, dep2;
    logic [ROB_W-1:0] tag1, tag2, rob;
    logic [31:0]      v1, v2;
    logic [2:0]       op;
    logic [6:0]       typ;
    logic             oth;
  } ent_t;

  ent_t q[$];          // waiting ops, oldest at the front
  ent_t m_out;
  logic m_valid = 1'b0;
  logic cmp_en  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cdb_lookup(input logic [ROB_W-1:0] tag, output logic hit, output logic [31:0] val);
    hit = 1'b0;
    val = '0;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (!hit && cdb_valid[c] && cdb_rob_id[c*ROB_W +: ROB_W] == tag) begin
        hit = 1'b1;
        val = cdb_value[c*32 +: 32];
      end
    end
  endtask

  always @(posedge clk) begin : model
    int          n0, pick;
    ent_t        e;
    logic        h;
    logic [31:0] v;
    if (!rst_n || (rdy && rob_clear)) begin
      q.delete();
      m_valid = 1'b0;
      m_out   = '{default: '0};
    end else if (rdy) begin
      n0   = q.size();
      pick = -1;
      if (!m_valid || alu_ready)
        for (int i = 0; i < q.size(); i++)
          if (pick < 0 && !q[i].dep1 && !q[i].dep2) pick = i;
      if (pick >= 0) begin
        m_out   = q[pick];
        m_valid = 1'b1;
        q.delete(pick);
      end else if (alu_ready) begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        if (e.dep1) begin cdb_lookup(e.tag1, h, v); if (h) begin e.dep1 = 1'b0; e.v1 = v; end end
        if (e.dep2) begin cdb_lookup(e.tag2, h, v); if (h) begin e.dep2 = 1'b0; e.v2 = v; end end
        q[i] = e;
      end
      if (issue_valid) begin
        if (n0 >= RS_SIZE) begin
          errors++;
          $display("FAIL protocol @%0t: issue while full", $time);
        end else begin
          e.rob = issue_rob_id; e.op = issue_op; e.typ = issue_type; e.oth = issue_op_other;
          e.tag1 = issue_tag1; e.tag2 = issue_tag2;
          e.dep1 = issue_dep1; e.dep2 = issue_dep2;
          e.v1 = issue_v1; e.v2 = issue_v2;
          if (e.dep1) begin cdb_lookup(e.tag1, h, v); if (h) begin e.dep1 = 1'b0; e.v1 = v; end end
          if (e.dep2) begin cdb_lookup(e.tag2, h, v); if (h) begin e.dep2 = 1'b0; e.v2 = v; end end
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rs_count", 32'(rs_count), q.size());
      chk("rs_full", 32'(rs_full), 32'(q.size() == RS_SIZE));
      chk("alu_valid", 32'(alu_valid), 32'(m_valid));
      if (m_valid) begin
        chk("alu_rob_id", 32'(alu_rob_id), 32'(m_out.rob));
        chk("alu_v1", alu_v1, m_out.v1);
        chk("alu_v2", alu_v2, m_out.v2);
        chk("alu_op", 32'(alu_op), 32'(m_out.op));
        chk("alu_type", 32'(alu_type), 32'(m_out.typ));
        chk("alu_op_other", 32'(alu_op_other), 32'(m_out.oth));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1'b1; rob_clear = 1'b0; issue_valid = 1'b0; cdb_valid = '0;
  endtask

  task automatic drive_issue(input logic [ROB_W-1:0] rid, input logic d1, input logic [ROB_W-1:0] t1,
                             input logic [31:0] v1, input logic d2, input logic [ROB_W-1:0] t2,
                             input logic [31:0] v2);
    issue_valid = 1'b1; issue_rob_id = rid;
    issue_op = 3'(rid); issue_type = 7'b0110011; issue_op_other = rid[0];
    issue_dep1 = d1; issue_tag1 = t1; issue_v1 = v1;
    issue_dep2 = d2; issue_tag2 = t2; issue_v2 = v2;
  endtask

  task automatic cdb(input int c, input logic [ROB_W-1:0] tag, input logic [31:0] val);
    cdb_valid[c] = 1'b1;
    cdb_rob_id[c*ROB_W +: ROB_W] = tag;
    cdb_value[c*32 +: 32] = val;
  endtask

  initial begin
    rst_n = 1'b0; alu_ready = 1'b0;
    idle();
    issue_op = '0; issue_type = '0; issue_op_other = 1'b0; issue_v1 = '0; issue_v2 = '0;
    issue_dep1 = 1'b0; issue_dep2 = 1'b0; issue_tag1 = '0; issue_tag2 = '0; issue_rob_id = '0;
    cdb_rob_id = '0; cdb_value = '0;
    repeat (2) cyc();
    chk("reset rs_count", 32'(rs_count), 0);
    chk("reset rs_full", 32'(rs_full), 0);
    chk("reset alu_valid", 32'(alu_valid), 0);
    chk("reset alu_v1", alu_v1, 0);
    chk("reset alu_rob_id", 32'(alu_rob_id), 0);
    rst_n = 1'b1; cmp_en = 1'b1;

    // wakeup via channel 1
    alu_ready = 1'b1;
    drive_issue(5, 1, 2, 0, 0, 0, 32'h77); cyc(); issue_valid = 1'b0;
    chk("wake count", 32'(rs_count), 1);
    cdb(1, 2, 32'h1234); cyc(); cdb_valid = '0;
    chk("wake not yet", 32'(alu_valid), 0);
    cyc();
    chk("wake valid", 32'(alu_valid), 1);
    chk("wake v1", alu_v1, 32'h1234);
    chk("wake rob", 32'(alu_rob_id), 5);
    cyc();
    chk("wake drop", 32'(alu_valid), 0);

    // issue-cycle bypass
    drive_issue(6, 0, 0, 32'h11, 1, 7, 32'hBAD); cdb(0, 7, 32'hDEAD); cyc(); idle();
    cyc();
    chk("bypass valid", 32'(alu_valid), 1);
    chk("bypass v2", alu_v2, 32'hDEAD);
    cyc();

    // stale tag on a ready operand; lowest channel wins on double match
    drive_issue(8, 0, 4, 32'h55, 1, 6, 0); cyc(); issue_valid = 1'b0;
    cdb(0, 4, 32'h99); cyc(); cdb_valid = '0;
    chk("stale still waiting", 32'(alu_valid), 0);
    cdb(0, 6, 32'h66); cdb(1, 6, 32'h77); cyc(); cdb_valid = '0;
    cyc();
    chk("stale v1", alu_v1, 32'h55);
    chk("lowest ch v2", alu_v2, 32'h66);
    cyc();

    // age order with reuse of a freed low entry
    drive_issue(14, 1, 8, 0, 0, 0, 1); cyc();
    drive_issue(1, 1, 9, 0, 0, 0, 2); cyc(); issue_valid = 1'b0;
    cdb(0, 8, 32'hA8); cyc(); cdb_valid = '0;
    cyc();
    chk("age first rob", 32'(alu_rob_id), 14);
    drive_issue(2, 1, 9, 0, 0, 0, 3); cyc();
    drive_issue(3, 1, 9, 0, 0, 0, 4); cyc(); issue_valid = 1'b0;
    chk("age count", 32'(rs_count), 3);
    cdb(1, 9, 32'h99); cyc(); cdb_valid = '0;
    cyc(); chk("age order 1", 32'(alu_rob_id), 1);
    cyc(); chk("age order 2", 32'(alu_rob_id), 2);
    cyc(); chk("age order 3", 32'(alu_rob_id), 3);
    cyc(); chk("age drained", 32'(alu_valid), 0);

    // backpressure until full, then one dispatch per cycle
    alu_ready = 1'b0;
    for (int k = 0; k <= RS_SIZE; k++) begin
      drive_issue(ROB_W'(k), 0, 0, 32'(k), 0, 0, ~32'(k)); cyc();
    end
    issue_valid = 1'b0;
    chk("full flag", 32'(rs_full), 1);
    chk("full count", 32'(rs_count), RS_SIZE);
    repeat (2) cyc();
    chk("hold rob", 32'(alu_rob_id), 0);
    chk("hold valid", 32'(alu_valid), 1);
    alu_ready = 1'b1;
    for (int k = 1; k <= RS_SIZE; k++) begin
      cyc();
      chk("drain rob", 32'(alu_rob_id), k);
      if (k == 1) chk("full drops", 32'(rs_full), 0);
    end
    cyc();
    chk("drain empty", 32'(rs_count), 0);

    // flush
    for (int k = 0; k < 3; k++) begin
      drive_issue(ROB_W'(10 + k), 0, 0, 32'(k), 0, 0, 0); cyc();
    end
    issue_valid = 1'b0; rob_clear = 1'b1; cyc(); rob_clear = 1'b0;
    chk("flush count", 32'(rs_count), 0);
    chk("flush valid", 32'(alu_valid), 0);
    repeat (2) begin cyc(); chk("flush no dispatch", 32'(alu_valid), 0); end

    // rdy freeze
    drive_issue(4, 0, 0, 32'h44, 0, 0, 0); cyc(); issue_valid = 1'b0;
    rdy = 1'b0; cyc();
    chk("freeze no load", 32'(alu_valid), 0);
    rdy = 1'b1; cyc();
    chk("unfreeze load", 32'(alu_rob_id), 4);
    rdy = 1'b0; cyc();
    chk("freeze hold", 32'(alu_valid), 1);
    rdy = 1'b1; cyc();

    // random traffic
    repeat (3000) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      rdy       = ($urandom_range(0, 9) != 0);
      rob_clear = ($urandom_range(0, 79) == 0);
      alu_ready = ($urandom_range(0, 9) < 7);
      if (q.size() < RS_SIZE && $urandom_range(0, 1) == 1)
        drive_issue(ROB_W'($urandom), 1'($urandom), ROB_W'($urandom_range(0, 3)), $urandom,
                    1'($urandom), ROB_W'($urandom_range(0, 3)), $urandom);
      else
        issue_valid = 1'b0;
      cdb_valid = '0;
      for (int c = 0; c < NUM_CDB; c++)
        if ($urandom_range(0, 1) == 1) cdb(c, ROB_W'($urandom_range(0, 3)), $urandom);
      cyc();
    end
    rst_n = 1'b1;
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
